score_panel: RTL

SCORE_PANEL -- requirements
Module: score_panel

---
 rtl/score_panel_pkg.sv | 13 +
 rtl/score_panel_bcd_digit_alu.sv | 42 ++++
 rtl/score_panel.sv | 137 +++++++++++++
 3 files changed

// File: rtl/score_panel_pkg.sv
// Shared types and constants for the score panel: BCD digit type, BCD limits
// and the default visible raster size.
package score_panel_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX            = 4'd9;
  localparam bcd_t ROM_FALLBACK_GLYPH = 4'd8;

  localparam int SCREEN_W_DEF = 800;
  localparam int SCREEN_H_DEF = 600;

endpackage

// File: rtl/score_panel_bcd_digit_alu.sv
// One BCD digit of add or subtract with carry/borrow in and out. Chained
// least-significant first to form a multi-digit ripple adder/subtractor.
module bcd_digit_alu
  import score_panel_pkg::*;
(
  input  bcd_t a,
  input  bcd_t b,
  input  logic sub,
  input  logic cin,
  output bcd_t y,
  output logic cout
);

  logic        [4:0] sum_raw;
  logic signed [5:0] diff_raw;
  logic signed [5:0] diff_adj;

  // Binary add/subtract then decimal correction into one BCD digit.
  always_comb begin
    sum_raw  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    diff_raw = signed'({2'b00, a}) - signed'({2'b00, b}) - signed'({5'd0, cin});
    diff_adj = diff_raw + 6'sd10;
    y        = '0;
    cout     = 1'b0;
    if (sub) begin
      if (diff_raw < 0) begin
        y    = diff_adj[3:0];
        cout = 1'b1;
      end else begin
        y    = diff_raw[3:0];
      end
    end else begin
      if (sum_raw > 5'd9) begin
        y    = 4'(sum_raw - 5'd10);
        cout = 1'b1;
      end else begin
        y    = sum_raw[3:0];
      end
    end
  end

endmodule

// File: rtl/score_panel.sv
// Score panel: BCD score with saturating add, decrement with game-over,
// high-score tracking, and a pixel path that addresses an external glyph ROM
// one pixel ahead so the ROM's one-cycle latency lines up with the raster.
module score_panel
  import score_panel_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 60,
  parameter int DIGIT_H    = 80,
  parameter int ORIGIN_X   = 560,
  parameter int ORIGIN_Y   = 0,
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    add,
  input  logic [3:0]              add_amt,
  input  logic                    decr,
  input  logic                    decr_en,
  input  logic [11:0]             x_p,
  input  logic [11:0]             y_p,
  output logic [15:0]             rom_addr,
  input  logic                    rom_data,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] high_bcd,
  output logic                    gameover,
  output logic                    is_filled
);

  localparam int SW = 4*NUM_DIGITS;

  logic [SW-1:0]       score_q, score_d, high_q, high_d, alu_sum;
  logic                gameover_q, gameover_d;
  logic                in_region_q, in_region_d, blank_q, blank_d;
  logic                dec_acc, add_acc;
  bcd_t                amt;
  logic [NUM_DIGITS:0] chain;

  // Accept strobes: decrement wins over add, nothing is accepted after game-over.
  always_comb begin
    dec_acc  = decr & decr_en & ~gameover_q;
    add_acc  = add & ~dec_acc & ~gameover_q;
    amt      = (add_amt > BCD_MAX) ? BCD_MAX : add_amt;
    chain[0] = dec_acc;
  end

  // Digit 0 takes the addend on add, or a borrow-in of 1 on decrement.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_alu
    bcd_digit_alu u_alu (
      .a    (score_q[4*k +: 4]),
      .b    ((k == 0 && !dec_acc) ? amt : 4'd0),
      .sub  (dec_acc),
      .cin  (chain[k]),
      .y    (alu_sum[4*k +: 4]),
      .cout (chain[k+1])
    );
  end

  // Next score, game-over flag and high score.
  always_comb begin
    score_d = score_q;
    if (gameover_q) begin
      score_d = '0;
    end else if (dec_acc) begin
      score_d = chain[NUM_DIGITS] ? '0 : alu_sum;
    end else if (add_acc) begin
      score_d = chain[NUM_DIGITS] ? {NUM_DIGITS{BCD_MAX}} : alu_sum;
    end
    gameover_d = gameover_q | (dec_acc && (score_q <= SW'(1)));
    high_d = high_q;
    if (score_q > high_d) high_d = score_q;
    if (score_d > high_d) high_d = score_d;
  end

  // Score, high-score, game-over and pixel alignment registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q     <= '0;
      high_q      <= '0;
      gameover_q  <= 1'b0;
      in_region_q <= 1'b0;
      blank_q     <= 1'b0;
    end else begin
      score_q     <= score_d;
      high_q      <= high_d;
      gameover_q  <= gameover_d;
      in_region_q <= in_region_d;
      blank_q     <= blank_d;
    end
  end

  int   x_i, y_i, nx, ny, left, row, col, addr;
  logic hit, zero_run;
  bcd_t dval, glyph;

  // Predict the next raster pixel and form the ROM address for it.
  always_comb begin
    x_i = {20'd0, x_p};
    y_i = {20'd0, y_p};
    if (x_i == SCREEN_W-1) begin
      nx = 0;
      ny = (y_i == SCREEN_H-1) ? 0 : y_i + 1;
    end else begin
      nx = x_i + 1;
      ny = y_i;
    end
    zero_run = 1'b1;
    hit      = 1'b0;
    row      = 0;
    col      = 0;
    left     = 0;
    dval     = '0;
    blank_d  = 1'b0;
    for (int k = NUM_DIGITS-1; k >= 0; k--) begin
      zero_run = zero_run & (score_q[4*k +: 4] == 4'd0);
      left     = ORIGIN_X + (NUM_DIGITS-1-k)*DIGIT_W;
      if (nx >= left && nx < left + DIGIT_W && ny >= ORIGIN_Y && ny < ORIGIN_Y + DIGIT_H) begin
        hit     = 1'b1;
        col     = nx - left;
        row     = ny - ORIGIN_Y;
        dval    = score_q[4*k +: 4];
        blank_d = (k != 0) && zero_run;
      end
    end
    glyph       = (dval > BCD_MAX) ? ROM_FALLBACK_GLYPH : dval;
    addr        = hit ? (int'(glyph)*DIGIT_W*DIGIT_H + row*DIGIT_W + col) : 0;
    rom_addr    = addr[15:0];
    in_region_d = hit;
  end

  assign is_filled = rom_data & in_region_q & ~blank_q;
  assign score_bcd = score_q;
  assign high_bcd  = high_q;
  assign gameover  = gameover_q;

endmodule
